ds_operand_unit: RTL and testbench

DS_OPERAND_UNIT -- requirements
Module: ds_operand_unit

---
 rtl/mycpu_pkg.sv | 18 +
 rtl/fwd_sel.sv | 41 ++++
 rtl/ds_operand_unit.sv | 96 +++++++++
 tb/tb_ds_operand_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared CPU-wide constants and small helpers used by the decode-stage operand logic.
package mycpu_pkg;

    localparam int REG_AW     = 5;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_NREAD  = 2;
    localparam int DEF_NFWD   = 3;
    localparam int DEF_BUS_W  = 64;
    localparam int STALL_W    = 16;

    typedef logic [REG_AW-1:0] reg_addr_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// One read port's operand resolution: youngest matching bypass source wins, r0 reads as zero,
// and a pending (not-ready) youngest match raises a hazard when the operand is needed.
module fwd_sel
    import mycpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NFWD   = DEF_NFWD
) (
    input  logic [REG_AW-1:0]      rd_addr,
    input  logic                   rd_need,
    input  logic [DATA_W-1:0]      rf_rdata,
    input  logic [NFWD-1:0]        fwd_valid,
    input  logic [NFWD-1:0]        fwd_we,
    input  logic [NFWD*REG_AW-1:0] fwd_addr,
    input  logic [NFWD-1:0]        fwd_ready,
    input  logic [NFWD*DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0]      src_value,
    output logic                   hazard
);

    logic found;

    always_comb begin
        src_value = rf_rdata;
        hazard    = 1'b0;
        found     = 1'b0;
        // Scan from youngest to oldest; only the first match may decide data and readiness.
        for (int i = 0; i < NFWD; i++) begin
            if (!found && fwd_valid[i] && fwd_we[i] && (rd_addr != '0) &&
                (fwd_addr[i*REG_AW +: REG_AW] == rd_addr)) begin
                found     = 1'b1;
                src_value = fwd_data[i*DATA_W +: DATA_W];
                hazard    = rd_need & ~fwd_ready[i];
            end
        end
        if (rd_addr == '0) begin
            src_value = '0;
        end
    end

endmodule

// File: rtl/ds_operand_unit.sv
// Decode-stage payload latch with operand forwarding, load-use interlock and a saturating
// stall counter.
module ds_operand_unit
    import mycpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREAD  = DEF_NREAD,
    parameter int NFWD   = DEF_NFWD,
    parameter int BUS_W  = DEF_BUS_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fs_to_ds_valid,
    input  logic [BUS_W-1:0]        fs_to_ds_bus,
    output logic                    ds_allowin,
    input  logic                    es_allowin,
    output logic                    ds_to_es_valid,
    output logic                    ds_valid,
    output logic [BUS_W-1:0]        ds_bus,
    input  logic                    flush,
    input  logic [NREAD*REG_AW-1:0] rd_addr,
    input  logic [NREAD-1:0]        rd_need,
    input  logic [NREAD*DATA_W-1:0] rf_rdata,
    input  logic [NFWD-1:0]         fwd_valid,
    input  logic [NFWD-1:0]         fwd_we,
    input  logic [NFWD*REG_AW-1:0]  fwd_addr,
    input  logic [NFWD-1:0]         fwd_ready,
    input  logic [NFWD*DATA_W-1:0]  fwd_data,
    output logic [NREAD*DATA_W-1:0] src_value,
    output logic [STALL_W-1:0]      stall_cnt
);

    logic [NREAD-1:0]   port_hazard;
    logic               hazard;
    logic               ready_go;
    logic               load;
    logic               ds_valid_q, ds_valid_d;
    logic [BUS_W-1:0]   ds_bus_q, ds_bus_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    for (genvar p = 0; p < NREAD; p++) begin : g_port
        fwd_sel #(
            .DATA_W (DATA_W),
            .NFWD   (NFWD)
        ) u_fwd_sel (
            .rd_addr   (rd_addr[p*REG_AW +: REG_AW]),
            .rd_need   (rd_need[p]),
            .rf_rdata  (rf_rdata[p*DATA_W +: DATA_W]),
            .fwd_valid (fwd_valid),
            .fwd_we    (fwd_we),
            .fwd_addr  (fwd_addr),
            .fwd_ready (fwd_ready),
            .fwd_data  (fwd_data),
            .src_value (src_value[p*DATA_W +: DATA_W]),
            .hazard    (port_hazard[p])
        );
    end

    assign hazard         = |port_hazard;
    assign ready_go       = ~hazard;
    assign ds_allowin     = ~ds_valid_q | (ready_go & es_allowin);
    assign ds_to_es_valid = ds_valid_q & ready_go & ~flush;
    assign ds_valid       = ds_valid_q;
    assign ds_bus         = ds_bus_q;
    assign stall_cnt      = stall_cnt_q;

    // Reset and flush both suppress a payload load that would otherwise happen this edge.
    assign load = ds_allowin & fs_to_ds_valid & ~flush & ~reset;

    always_comb begin
        ds_valid_d = ds_valid_q;
        if (flush) begin
            ds_valid_d = 1'b0;
        end else if (ds_allowin) begin
            ds_valid_d = fs_to_ds_valid;
        end
        ds_bus_d    = load ? fs_to_ds_bus : ds_bus_q;
        stall_cnt_d = (ds_valid_q & hazard & ~flush) ? sat_inc(stall_cnt_q) : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ds_valid_q  <= ds_valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Payload register carries data only; it is deliberately left out of reset.
    always_ff @(posedge clk) begin
        ds_bus_q <= ds_bus_d;
    end

endmodule

// File: tb/tb_ds_operand_unit.sv
// Self-checking bench for ds_operand_unit: directed corner cases plus randomized traffic
// compared against a behavioural model of the decode stage.
module tb_ds_operand_unit;

    localparam int DW = 32;
    localparam int NR = 2;
    localparam int NF = 3;
    localparam int BW = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              fs_to_ds_valid;
    logic [BW-1:0]     fs_to_ds_bus;
    logic              ds_allowin;
    logic              es_allowin;
    logic              ds_to_es_valid;
    logic              ds_valid;
    logic [BW-1:0]     ds_bus;
    logic              flush;
    logic [NR*5-1:0]   rd_addr;
    logic [NR-1:0]     rd_need;
    logic [NR*DW-1:0]  rf_rdata;
    logic [NF-1:0]     fwd_valid;
    logic [NF-1:0]     fwd_we;
    logic [NF*5-1:0]   fwd_addr;
    logic [NF-1:0]     fwd_ready;
    logic [NF*DW-1:0]  fwd_data;
    logic [NR*DW-1:0]  src_value;
    logic [15:0]       stall_cnt;

    ds_operand_unit #(.DATA_W(DW), .NREAD(NR), .NFWD(NF), .BUS_W(BW)) dut (
        .clk(clk), .reset(reset), .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
        .ds_allowin(ds_allowin), .es_allowin(es_allowin), .ds_to_es_valid(ds_to_es_valid),
        .ds_valid(ds_valid), .ds_bus(ds_bus), .flush(flush), .rd_addr(rd_addr),
        .rd_need(rd_need), .rf_rdata(rf_rdata), .fwd_valid(fwd_valid), .fwd_we(fwd_we),
        .fwd_addr(fwd_addr), .fwd_ready(fwd_ready), .fwd_data(fwd_data),
        .src_value(src_value), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    bit          m_valid;
    logic [63:0] m_bus;
    bit          m_bus_known;
    int          m_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int find_src(int p);
        for (int i = 0; i < NF; i++)
            if (fwd_valid[i] && fwd_we[i] && rd_addr[p*5 +: 5] != 0 &&
                fwd_addr[i*5 +: 5] == rd_addr[p*5 +: 5])
                return i;
        return -1;
    endfunction

    function automatic logic [31:0] exp_src(int p);
        int s;
        if (rd_addr[p*5 +: 5] == 0) return 32'h0;
        s = find_src(p);
        if (s >= 0) return fwd_data[s*DW +: DW];
        return rf_rdata[p*DW +: DW];
    endfunction

    function automatic bit exp_hazard();
        int s;
        for (int p = 0; p < NR; p++) begin
            s = find_src(p);
            if (rd_need[p] && s >= 0 && !fwd_ready[s]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check_all(input string tag);
        bit rg;
        #1;
        rg = !exp_hazard();
        check({tag, "_valid"}, {63'h0, ds_valid}, {63'h0, m_valid});
        check({tag, "_allowin"}, {63'h0, ds_allowin}, {63'h0, (!m_valid || (rg && es_allowin))});
        check({tag, "_to_es"}, {63'h0, ds_to_es_valid}, {63'h0, (m_valid && rg && !flush)});
        check({tag, "_cnt"}, {48'h0, stall_cnt}, 64'(m_cnt));
        for (int p = 0; p < NR; p++)
            check({tag, "_src"}, {32'h0, src_value[p*DW +: DW]}, {32'h0, exp_src(p)});
        if (m_bus_known) check({tag, "_bus"}, ds_bus, m_bus);
    endtask

    // Advance one clock, updating the model from the inputs currently applied.
    task automatic tick();
        bit hz, allow;
        hz    = exp_hazard();
        allow = !m_valid || (!hz && es_allowin);
        if (reset) begin
            m_valid = 1'b0;
            m_cnt   = 0;
        end else begin
            if (m_valid && hz && !flush && m_cnt < 65535) m_cnt++;
            if (flush) m_valid = 1'b0;
            else if (allow) begin
                m_valid = fs_to_ds_valid;
                if (fs_to_ds_valid) begin
                    m_bus = fs_to_ds_bus;
                    m_bus_known = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        fwd_valid = '0; fwd_we = '0; fwd_addr = '0; fwd_ready = '1; fwd_data = '0;
        rd_addr = '0; rd_need = '0; rf_rdata = '0;
    endtask

    task automatic set_src(input int i, input logic [4:0] a, input bit rdy, input logic [31:0] d);
        fwd_valid[i] = 1'b1; fwd_we[i] = 1'b1; fwd_addr[i*5 +: 5] = a;
        fwd_ready[i] = rdy; fwd_data[i*DW +: DW] = d;
    endtask

    task automatic load_payload(input logic [63:0] b);
        clear_fwd();
        fs_to_ds_valid = 1'b1; fs_to_ds_bus = b; es_allowin = 1'b1; flush = 1'b0;
        tick();
        fs_to_ds_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] held;
        clear_fwd();
        reset = 1'b1; fs_to_ds_valid = 1'b0; fs_to_ds_bus = '0; es_allowin = 1'b1; flush = 1'b0;
        m_valid = 1'b0; m_cnt = 0; m_bus = '0; m_bus_known = 1'b0;
        @(posedge clk); #1;
        tick();
        reset = 1'b0;
        check_all("reset");

        // Youngest source beats an older one on the same register
        load_payload(64'h1111_2222_3333_4444);
        rd_addr[4:0] = 5'd5; rd_need = 2'b01;
        set_src(0, 5'd5, 1'b1, 32'h1234);
        set_src(2, 5'd5, 1'b1, 32'hFFFF);
        check_all("prio");
        check("prio_val", {32'h0, src_value[31:0]}, 64'h1234);
        check("prio_go", {63'h0, ds_to_es_valid}, 64'h1);
        tick();

        // Pending youngest producer stalls port 1 for two cycles
        load_payload(64'hAAAA_BBBB_CCCC_DDDD);
        held = 64'hAAAA_BBBB_CCCC_DDDD;
        fs_to_ds_valid = 1'b1; fs_to_ds_bus = 64'h5555_6666_7777_8888;
        rd_addr[9:5] = 5'd7; rd_need = 2'b10;
        set_src(0, 5'd7, 1'b0, 32'hDEAD_BEEF);
        set_src(1, 5'd7, 1'b1, 32'h0BAD_0BAD);
        check_all("stall0");
        check("stall_to_es0", {63'h0, ds_to_es_valid}, 64'h0);
        tick();
        check_all("stall1");
        check("stall_to_es1", {63'h0, ds_to_es_valid}, 64'h0);
        tick();
        check("stall_cnt2", {48'h0, stall_cnt}, 64'h2);
        check("stall_bus_held", ds_bus, held);
        fwd_ready[0] = 1'b1;
        check_all("stall_release");
        tick();

        // Register zero is never forwarded and never stalls
        fs_to_ds_valid = 1'b0;
        clear_fwd();
        rd_need = 2'b11;
        for (int i = 0; i < NF; i++) set_src(i, 5'd0, 1'b0, 32'hCAFE_0000 + i);
        rf_rdata = {32'h1357_9BDF, 32'h2468_ACE0};
        check_all("r0");
        check("r0_src", {32'h0, src_value[31:0]}, 64'h0);
        check("r0_go", {63'h0, ds_to_es_valid}, 64'h1);
        tick();

        // Flush wins over a simultaneous load
        load_payload(64'h0F0F_0F0F_0F0F_0F0F);
        flush = 1'b1; fs_to_ds_valid = 1'b1; fs_to_ds_bus = 64'hF0F0_F0F0_F0F0_F0F0;
        tick();
        flush = 1'b0; fs_to_ds_valid = 1'b0;
        check("flush_valid", {63'h0, ds_valid}, 64'h0);
        check("flush_bus", ds_bus, 64'h0F0F_0F0F_0F0F_0F0F);
        check_all("flush");

        // Reset in the middle of a stall
        load_payload(64'h1234_5678_9ABC_DEF0);
        rd_addr[9:5] = 5'd7; rd_need = 2'b10;
        set_src(0, 5'd7, 1'b0, 32'h1);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_valid", {63'h0, ds_valid}, 64'h0);
        check("rst_cnt", {48'h0, stall_cnt}, 64'h0);
        check("rst_allowin", {63'h0, ds_allowin}, 64'h1);
        check_all("rst_stall");

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            reset          = ($urandom_range(0, 99) == 0);
            flush          = ($urandom_range(0, 15) == 0);
            fs_to_ds_valid = $urandom_range(0, 1);
            fs_to_ds_bus   = {$urandom, $urandom};
            es_allowin     = ($urandom_range(0, 3) != 0);
            for (int p = 0; p < NR; p++) rd_addr[p*5 +: 5] = 5'($urandom_range(0, 3));
            rd_need   = 2'($urandom);
            rf_rdata  = {$urandom, $urandom};
            fwd_valid = 3'($urandom);
            fwd_we    = 3'($urandom);
            for (int i = 0; i < NF; i++) fwd_addr[i*5 +: 5] = 5'($urandom_range(0, 3));
            fwd_ready = 3'($urandom | $urandom);
            fwd_data  = {$urandom, $urandom, $urandom};
            check_all("rand");
            tick();
        end
        reset = 1'b0; flush = 1'b0;

        // Saturation of the stall counter
        reset = 1'b1; tick(); reset = 1'b0;
        load_payload(64'h7777_7777_7777_7777);
        rd_addr[4:0] = 5'd9; rd_need = 2'b01;
        set_src(1, 5'd9, 1'b0, 32'h9);
        while (m_cnt < 65534) tick();
        check("sat_pre", {48'h0, stall_cnt}, 64'hFFFE);
        tick(); tick(); tick();
        check("sat_cnt", {48'h0, stall_cnt}, 64'hFFFF);
        check_all("sat");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
